// File: rtl/rx_module.sv
// UART-style serial receiver: two-flop line synchronizer, start-bit detection
// with glitch rejection, mid-bit sampling, optional parity and stop-bit checks.
// Outputs a byte per good frame with one-cycle valid/parity_err/frame_err strobes.
module rx_module #(
    parameter int CLKS_PER_BIT = 1,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    // In-bit position at which each bit is sampled.
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    d;
    logic          mismatch;
    logic          rx_meta;
    logic          rx_s;

    logic sample;
    logic bit_end;

    assign sample  = (cnt == HALF_C);
    assign bit_end = (cnt == LAST_C);
    assign busy    = (state != IDLE);

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM with registered byte and one-cycle status strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            d          <= '0;
            mismatch   <= 1'b0;
            data_out   <= 8'h00;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    // The detection cycle is in-bit count 0 of the start bit.
                    // At one clock per bit the start bit ends right here.
                    if (enable && !rx_s) begin
                        bit_idx  <= '0;
                        mismatch <= 1'b0;
                        if (CLKS_PER_BIT == 1) begin
                            state <= DATA;
                            cnt   <= '0;
                        end else begin
                            state <= START;
                            cnt   <= ONE_C;
                        end
                    end
                end

                START: begin
                    // A line that is high again at mid-bit was only a glitch.
                    if (sample && rx_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (bit_end) begin
                        state <= DATA;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end

                DATA: begin
                    if (sample) d[bit_idx] <= rx_s;
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end

                PARITY: begin
                    if (sample) mismatch <= rx_s ^ (^d) ^ PARITY_ODD;
                    if (bit_end) begin
                        state <= STOP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end

                STOP: begin
                    // Leave at the sample point so a start bit immediately
                    // following the stop bit is still caught from IDLE.
                    if (sample) begin
                        cnt <= '0;
                        if (rx_s) begin
                            valid      <= 1'b1;
                            data_out   <= d;
                            parity_err <= PARITY_EN & mismatch;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end

                WAIT_IDLE: begin
                    // Break or stuck-low line: hold off until it idles high.
                    if (rx_s) state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
